// File: rtl/desc_stream_pkg.sv
// Shared constants and types for the descriptor word streamer.
// Word width is PIX_W * PIX_PER_WORD; a descriptor is 16 rows x 4 groups.
package desc_stream_pkg;

  localparam int PIX_W           = 8;
  localparam int PIX_PER_WORD    = 4;
  localparam int WORD_W          = PIX_W * PIX_PER_WORD;
  localparam int WORDS_PER_DESC  = 64;
  localparam int DESC_ROWS       = 16;
  localparam int DESC_COL_GROUPS = 4;
  localparam int FIFO_DEPTH      = 4;

  typedef logic [WORD_W-1:0] desc_word_t;

  function automatic desc_word_t pack_word(
    input logic [WORD_W-PIX_W-1:0] hi,
    input logic [PIX_W-1:0]        lo
  );
    return {hi, lo};
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Small synchronous FIFO with wrap-bit pointers and a combinational head.
// Head reads as zero while empty so the output bus is quiet after flush.
module sync_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clear,
  input  logic                     push,
  input  logic [WIDTH-1:0]         din,
  input  logic                     pop,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0])
                 && (wr_ptr[AW] != rd_ptr[AW]);
  assign count   = wr_ptr - rd_ptr;
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = empty ? '0 : mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (do_push && !clear)
      mem[wr_ptr[AW-1:0]] <= din;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push)
        wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)
        rd_ptr <= rd_ptr + 1'b1;
    end
  end

endmodule

// File: rtl/desc_word_streamer.sv
// Packs a raster pixel stream into 32-bit words and hands them to the
// NCC engine over a ready/ack handshake, tracking row and column group.
module desc_word_streamer
  import desc_stream_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        clear,
  input  logic [7:0]  pix_in,
  input  logic        pix_valid,
  output logic        pix_ready,
  output logic [31:0] desc_data_out,
  output logic        desc_data_ready,
  input  logic        desc_ack,
  output logic [3:0]  word_row,
  output logic [1:0]  word_col,
  output logic        desc_done,
  output logic [2:0]  fifo_count,
  output logic        proto_err
);

  logic [1:0]             byte_cnt;
  logic [WORD_W-PIX_W-1:0] pack_q;
  logic [5:0]             word_cnt;
  logic                   done_q;
  logic                   err_q;
  logic                   accept;
  logic                   push;
  logic                   pop;
  logic                   full;
  logic                   empty;
  desc_word_t             push_word;
  desc_word_t             head;

  assign pix_ready = (byte_cnt != 2'd3) || !full;
  assign accept    = pix_valid && pix_ready;
  assign push      = accept && (byte_cnt == 2'd3) && !clear;
  assign pop       = desc_ack && !empty && !clear;
  assign push_word = pack_word(pack_q, pix_in);

  sync_fifo #(
    .WIDTH (WORD_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .clear (clear),
    .push  (push),
    .din   (push_word),
    .pop   (pop),
    .dout  (head),
    .full  (full),
    .empty (empty),
    .count (fifo_count)
  );

  // First pixel of a word lands in the most significant lane.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      byte_cnt <= 2'd0;
      pack_q   <= '0;
    end else if (clear) begin
      byte_cnt <= 2'd0;
      pack_q   <= '0;
    end else if (accept) begin
      byte_cnt <= byte_cnt + 2'd1;
      unique case (byte_cnt)
        2'd0:    pack_q[23:16] <= pix_in;
        2'd1:    pack_q[15:8]  <= pix_in;
        2'd2:    pack_q[7:0]   <= pix_in;
        default: pack_q        <= pack_q;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      word_cnt <= 6'd0;
      done_q   <= 1'b0;
    end else if (clear) begin
      word_cnt <= 6'd0;
      done_q   <= 1'b0;
    end else begin
      if (pop)
        word_cnt <= word_cnt + 6'd1;
      done_q <= pop && (word_cnt == 6'(WORDS_PER_DESC - 1));
    end
  end

  // Sticky until reset; clear deliberately leaves it alone.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      err_q <= 1'b0;
    else if (desc_ack && empty)
      err_q <= 1'b1;
  end

  assign desc_data_out   = head;
  assign desc_data_ready = !empty;
  assign word_row        = word_cnt[5:2];
  assign word_col        = word_cnt[1:0];
  assign desc_done       = done_q;
  assign proto_err       = err_q;

endmodule

// File: tb/tb_desc_word_streamer.sv
// Directed self-checking bench for desc_word_streamer.
// Inputs change #1 after the rising edge; outputs are sampled there too.
module tb_desc_word_streamer;

  logic        clk = 1'b0;
  logic        rst;
  logic        clear;
  logic [7:0]  pix_in;
  logic        pix_valid;
  logic        pix_ready;
  logic [31:0] desc_data_out;
  logic        desc_data_ready;
  logic        desc_ack;
  logic [3:0]  word_row;
  logic [1:0]  word_col;
  logic        desc_done;
  logic [2:0]  fifo_count;
  logic        proto_err;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  desc_word_streamer dut (
    .clk             (clk),
    .rst             (rst),
    .clear           (clear),
    .pix_in          (pix_in),
    .pix_valid       (pix_valid),
    .pix_ready       (pix_ready),
    .desc_data_out   (desc_data_out),
    .desc_data_ready (desc_data_ready),
    .desc_ack        (desc_ack),
    .word_row        (word_row),
    .word_col        (word_col),
    .desc_done       (desc_done),
    .fifo_count      (fifo_count),
    .proto_err       (proto_err)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_clear();
    clear = 1'b1;
    tick();
    clear = 1'b0;
  endtask

  task automatic send(input logic [7:0] b);
    pix_in    = b;
    pix_valid = 1'b1;
    tick();
    pix_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; clear = 1'b0; pix_in = 8'h00;
    pix_valid = 1'b0; desc_ack = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    tick();
    tests++;
    if ({pix_ready, desc_data_ready, desc_done, proto_err} !== 4'b1000) begin
      fails++;
      $display("FAIL reset_flags: got %b expected 1000",
               {pix_ready, desc_data_ready, desc_done, proto_err});
    end
    tests++;
    if ({desc_data_out, word_row, word_col, fifo_count} !== 41'd0) begin
      fails++;
      $display("FAIL reset_vals: data=%h row=%0d col=%0d cnt=%0d expected zero",
               desc_data_out, word_row, word_col, fifo_count);
    end
    desc_ack = 1'b1;
    tick();
    desc_ack = 1'b0;
    tests++;
    if (proto_err !== 1'b1 || fifo_count !== 3'd0) begin
      fails++;
      $display("FAIL ack_empty: proto_err=%b cnt=%0d expected 1 0",
               proto_err, fifo_count);
    end
  endtask

  task automatic test_pack();
    do_clear();
    send(8'h01); send(8'h02); send(8'h03);
    tests++;
    if (desc_data_ready !== 1'b0) begin
      fails++;
      $display("FAIL early_ready: got %b expected 0", desc_data_ready);
    end
    send(8'h04);
    tests++;
    if (desc_data_ready !== 1'b1 || desc_data_out !== 32'h01020304) begin
      fails++;
      $display("FAIL pack_word: ready=%b data=%h expected 1 01020304",
               desc_data_ready, desc_data_out);
    end
    tests++;
    if (word_row !== 4'd0 || word_col !== 2'd0 || fifo_count !== 3'd1) begin
      fails++;
      $display("FAIL pack_pos: row=%0d col=%0d cnt=%0d expected 0 0 1",
               word_row, word_col, fifo_count);
    end
  endtask

  task automatic test_full();
    int ok;
    do_clear();
    for (int i = 0; i < 16; i++)
      send(8'(8'h10 + i));
    tests++;
    if (fifo_count !== 3'd4 || desc_data_out !== 32'h10111213) begin
      fails++;
      $display("FAIL fill: cnt=%0d head=%h expected 4 10111213",
               fifo_count, desc_data_out);
    end
    ok = 1;
    for (int i = 0; i < 3; i++) begin
      if (pix_ready !== 1'b1) ok = 0;
      send(8'(8'h20 + i));
    end
    tests++;
    if (ok != 1) begin
      fails++;
      $display("FAIL ready_lanes: got 0 expected 1 for bytes 1-3");
    end
    pix_in = 8'h23; pix_valid = 1'b1;
    tick(); tick();
    tests++;
    if (pix_ready !== 1'b0 || fifo_count !== 3'd4) begin
      fails++;
      $display("FAIL stall: ready=%b cnt=%0d expected 0 4", pix_ready, fifo_count);
    end
    desc_ack = 1'b1;
    #1;
    tests++;
    if (pix_ready !== 1'b0) begin
      fails++;
      $display("FAIL ready_ack_comb: got %b expected 0", pix_ready);
    end
    tick();
    desc_ack = 1'b0;
    tests++;
    if (pix_ready !== 1'b1 || fifo_count !== 3'd3 || desc_data_out !== 32'h14151617) begin
      fails++;
      $display("FAIL after_pop: ready=%b cnt=%0d head=%h expected 1 3 14151617",
               pix_ready, fifo_count, desc_data_out);
    end
    tick();
    pix_valid = 1'b0;
    tests++;
    if (fifo_count !== 3'd4) begin
      fails++;
      $display("FAIL fifth_word: cnt=%0d expected 4", fifo_count);
    end
    desc_ack = 1'b1;
    tick(); tick(); tick();
    tests++;
    if (desc_data_out !== 32'h20212223) begin
      fails++;
      $display("FAIL last_head: got %h expected 20212223", desc_data_out);
    end
    tick();
    desc_ack = 1'b0;
  endtask

  task automatic test_stream();
    int pops, bad, done_n, done_at, last_pop;
    logic [7:0]  b;
    logic [31:0] exp;
    pops = 0; bad = 0; done_n = 0; done_at = -1; last_pop = -2;
    do_clear();
    for (int c = 0; c < 264; c++) begin
      pix_valid = (c < 256);
      pix_in    = 8'(c);
      desc_ack  = 1'b1;
      if (desc_data_ready) begin
        b   = 8'(4 * pops);
        exp = {b, b + 8'd1, b + 8'd2, b + 8'd3};
        if (desc_data_out !== exp) bad++;
        if (pops == 5) begin
          tests++;
          if (desc_data_out !== 32'h14151617 || word_row !== 4'd1 || word_col !== 2'd1) begin
            fails++;
            $display("FAIL word5: data=%h row=%0d col=%0d expected 14151617 1 1",
                     desc_data_out, word_row, word_col);
          end
        end
        if (desc_data_out === 32'hFCFDFEFF) last_pop = c;
        pops++;
      end
      tick();
      if (desc_done === 1'b1) begin
        done_n++;
        done_at = c;
      end
    end
    pix_valid = 1'b0;
    desc_ack  = 1'b0;
    tests++;
    if (pops != 64 || bad != 0) begin
      fails++;
      $display("FAIL stream_words: pops=%0d bad=%0d expected 64 0", pops, bad);
    end
    tests++;
    if (done_n != 1 || done_at != last_pop) begin
      fails++;
      $display("FAIL done_pulse: count=%0d at=%0d expected 1 at %0d",
               done_n, done_at, last_pop);
    end
    tests++;
    if (word_row !== 4'd0 || word_col !== 2'd0) begin
      fails++;
      $display("FAIL wrap_pos: row=%0d col=%0d expected 0 0", word_row, word_col);
    end
  endtask

  task automatic test_back_to_back();
    do_clear();
    for (int i = 0; i < 11; i++)
      send(8'(8'h30 + i));
    tests++;
    if (fifo_count !== 3'd2 || desc_data_out !== 32'h30313233) begin
      fails++;
      $display("FAIL pre_same: cnt=%0d head=%h expected 2 30313233",
               fifo_count, desc_data_out);
    end
    pix_in = 8'h3B; pix_valid = 1'b1; desc_ack = 1'b1;
    tick();
    pix_valid = 1'b0;
    tests++;
    if (fifo_count !== 3'd2 || desc_data_out !== 32'h34353637) begin
      fails++;
      $display("FAIL same_edge: cnt=%0d head=%h expected 2 34353637",
               fifo_count, desc_data_out);
    end
    tick();
    desc_ack = 1'b0;
    tests++;
    if (fifo_count !== 3'd1 || desc_data_out !== 32'h38393A3B) begin
      fails++;
      $display("FAIL order: cnt=%0d head=%h expected 1 38393a3b",
               fifo_count, desc_data_out);
    end
  endtask

  task automatic test_clear_rst();
    do_clear();
    for (int i = 0; i < 10; i++)
      send(8'(8'h50 + i));
    desc_ack = 1'b1;
    pix_in = 8'h99; pix_valid = 1'b1;
    clear = 1'b1;
    tick();
    clear = 1'b0; desc_ack = 1'b0; pix_valid = 1'b0;
    tests++;
    if (fifo_count !== 3'd0 || desc_data_ready !== 1'b0 || desc_done !== 1'b0) begin
      fails++;
      $display("FAIL clear: cnt=%0d ready=%b done=%b expected 0 0 0",
               fifo_count, desc_data_ready, desc_done);
    end
    send(8'hAA); send(8'hBB); send(8'hCC); send(8'hDD);
    tests++;
    if (desc_data_out !== 32'hAABBCCDD || word_row !== 4'd0 || word_col !== 2'd0) begin
      fails++;
      $display("FAIL post_clear: data=%h row=%0d col=%0d expected aabbccdd 0 0",
               desc_data_out, word_row, word_col);
    end
    tests++;
    if (proto_err !== 1'b1) begin
      fails++;
      $display("FAIL err_sticky: got %b expected 1", proto_err);
    end
    send(8'h11); send(8'h22);
    #2;
    rst = 1'b1;
    #1;
    tests++;
    if ({pix_ready, desc_data_ready, desc_done, proto_err} !== 4'b1000 ||
        {desc_data_out, word_row, word_col, fifo_count} !== 41'd0) begin
      fails++;
      $display("FAIL async_rst: ready=%b dr=%b done=%b err=%b data=%h cnt=%0d expected reset values",
               pix_ready, desc_data_ready, desc_done, proto_err, desc_data_out, fifo_count);
    end
    tick();
    rst = 1'b0;
    send(8'h01); send(8'h02); send(8'h03); send(8'h04);
    tests++;
    if (desc_data_out !== 32'h01020304 || fifo_count !== 3'd1) begin
      fails++;
      $display("FAIL rst_partial: data=%h cnt=%0d expected 01020304 1",
               desc_data_out, fifo_count);
    end
  endtask

  initial begin
    test_reset();
    test_pack();
    test_full();
    test_stream();
    test_back_to_back();
    test_clear_rst();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
